// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : UART receive capture FSM feeding a byte FIFO with sticky overflow.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [15:0]   rx_out,
  output logic          rx_clear,
  input  logic          pop,
  input  logic          clr_ovf,
  output logic [15:0]   out,
  output logic [AW:0]   count
);

  localparam logic [AW:0] c_full_cnt = (AW+1)'(DEPTH);
  localparam logic [AW:0] c_one_cnt  = (AW+1)'(1);
  localparam logic [AW-1:0] c_one_ptr = AW'(1);

  typedef enum logic [1:0] {
    ST_ARM    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_push;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_ovf;

  logic          w_empty;
  logic          w_full;
  logic          w_do_pop;
  logic          w_do_push;
  logic          w_ovf_set;
  logic          w_unused_rx;

  assign w_unused_rx = ^rx_out[14:8];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_ARM;
    else          r_state <= w_state_nxt;
  end

  // SETTLE exists only to skip the receiver's stale status after a clear.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    rx_clear    = 1'b0;
    case (r_state)
      ST_ARM: begin
        rx_clear    = 1'b1;
        w_state_nxt = ST_SETTLE;
      end
      ST_SETTLE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (!rx_out[15]) begin
          w_push      = 1'b1;
          w_state_nxt = ST_ARM;
        end
      end
      default: w_state_nxt = ST_ARM;
    endcase
  end

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_full_cnt);
  assign w_do_pop  = pop && !w_empty;
  // A pop on a full FIFO frees the slot the coincident push needs.
  assign w_do_push = w_push && (!w_full || w_do_pop);
  assign w_ovf_set = w_push && w_full && !w_do_pop;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= rx_out[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_one_ptr;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_one_ptr;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_one_cnt;
        2'b01:   r_count <= r_count - c_one_cnt;
        default: r_count <= r_count;
      endcase
      if (w_ovf_set)    r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

  assign count = r_count;
  assign out   = {w_empty, r_ovf, 6'b0, w_empty ? 8'h00 : r_mem[r_rd_ptr]};

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// Directed testbench for uart_rx_fifo with a queue-based scoreboard.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [15:0]   rx_out;
  logic          rx_clear;
  logic          pop;
  logic          clr_ovf;
  logic [15:0]   out;
  logic [AW:0]   count;

  int            n_total = 0;
  int            n_pass  = 0;
  logic [7:0]    q[$];
  logic          m_ovf;

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .rx_out(rx_out), .rx_clear(rx_clear),
    .pop(pop), .clr_ovf(clr_ovf), .out(out), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  function automatic logic [15:0] exp_out();
    logic [7:0] head;
    head = (q.size() == 0) ? 8'h00 : q[0];
    return {(q.size() == 0), m_ovf, 6'b0, head};
  endfunction

  task automatic check_model(input string tag);
    check({tag, "_out"}, out, exp_out());
    check({tag, "_cnt"}, {11'b0, count}, 16'(q.size()));
  endtask

  // Present one byte in WAIT, optionally with pop/clr_ovf, then let the FSM re-arm.
  task automatic send(input logic [7:0] b, input bit with_pop, input bit with_clr);
    bit popped;
    rx_out  = {8'h00, b};
    pop     = with_pop;
    clr_ovf = with_clr;
    popped  = 0;
    if (with_pop && q.size() > 0) begin
      check("pre_pop_head", {8'h00, out[7:0]}, {8'h00, q[0]});
      void'(q.pop_front());
      popped = 1;
    end
    if (q.size() < DEPTH) q.push_back(b);
    else                  m_ovf = 1'b1;
    if (with_clr && !(q.size() == DEPTH && !popped && m_ovf)) m_ovf = 1'b0;
    tick();
    rx_out = 16'h8000; pop = 0; clr_ovf = 0;
    check("push_rxclr", {15'b0, rx_clear}, 16'h0001);
    check_model("push");
    tick();
    tick();
  endtask

  task automatic pop_one();
    pop = 1;
    if (q.size() > 0) begin
      check("pop_head", {8'h00, out[7:0]}, {8'h00, q[0]});
      void'(q.pop_front());
    end
    tick();
    pop = 0;
    check_model("pop");
  endtask

  initial begin
    reset_n = 0; rx_out = 16'h8000; pop = 0; clr_ovf = 0; m_ovf = 0;
    tick(); tick();
    check("rst_out", out, 16'h8000);
    check("rst_cnt", {11'b0, count}, 16'h0000);
    check("rst_rxclr", {15'b0, rx_clear}, 16'h0001);

    // Release: ARM holds for one more edge, then SETTLE, then WAIT.
    reset_n = 1;
    #1;
    check("arm_rxclr", {15'b0, rx_clear}, 16'h0001);
    tick();
    check("settle_rxclr", {15'b0, rx_clear}, 16'h0000);
    tick();
    tick();
    check("wait_rxclr", {15'b0, rx_clear}, 16'h0000);
    check_model("idle");

    // Single byte then pop.
    send(8'h41, 0, 0);
    check("byte41_out", out, 16'h0041);
    pop_one();
    check("empty_out", out, 16'h8000);

    // Fill, overflow with coincident clr_ovf (set wins), then clear.
    for (int i = 0; i < DEPTH; i++) send(8'(i), 0, 0);
    send(8'h55, 0, 1);
    check("ovf_out", out, 16'h4000);
    check("ovf_cnt", {11'b0, count}, 16'd16);
    clr_ovf = 1;
    m_ovf = 0;
    tick();
    clr_ovf = 0;
    check("clrovf_out", out, 16'h0000);

    // Full FIFO, push coincident with pop.
    send(8'hAA, 1, 0);
    check("fullpp_out", out, 16'h0001);
    check("fullpp_cnt", {11'b0, count}, 16'd16);
    for (int i = 0; i < DEPTH; i++) pop_one();
    check("drain_out", out, 16'h8000);

    // Interleaved stream across pointer wraps (first one pushes with pop on empty).
    for (int i = 0; i < 40; i++) send(8'(8'h10 + i), 1, 0);
    pop_one();

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 5; i++) send(8'(8'h60 + i), 0, 0);
    check("pre_rst_cnt", {11'b0, count}, 16'd5);
    #2;
    reset_n = 0;
    #1;
    q.delete();
    m_ovf = 0;
    check("async_out", out, 16'h8000);
    check("async_cnt", {11'b0, count}, 16'h0000);
    check("async_rxclr", {15'b0, rx_clear}, 16'h0001);
    tick();
    reset_n = 1;
    pop_one();
    check("pop_empty_out", out, 16'h8000);
    tick();
    tick();
    send(8'h7E, 0, 0);
    pop_one();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL expose parameter DEPTH, default 16, receive FIFO entries; power of two, 2..256.
REQ-002 The block SHALL expose parameter AW, default 4, pointer width = log2(DEPTH).
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 The block SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port rx_out  input  16  UART receiver status word: bit15=1 means waiting/no byte; bit15=0 means byte valid in [7:0].
REQ-006 The block SHALL have port rx_clear  output  1  clear request to the UART receiver; one cycle per request.
REQ-007 The block SHALL have port pop  input  1  CPU read strobe; consumes the head entry.
REQ-008 The block SHALL have port clr_ovf  input  1  clears the sticky overflow flag.
REQ-009 The block SHALL have port out  output  16  CPU view: [15]=empty, [14]=overflow, [13:8]=0, [7:0]=head byte (0 when empty).
REQ-010 The block SHALL have port count  output  AW+1  number of stored entries, 0..DEPTH.

Function
REQ-011 Capture FSM SHALL have three states: ARM, SETTLE, WAIT.
REQ-012 rx_clear SHALL be 1 exactly when the FSM is in ARM (Moore output).
REQ-013 ARM SHALL go to SETTLE unconditionally after one cycle.
REQ-014 SETTLE SHALL go to WAIT unconditionally after one cycle; rx_out is ignored in SETTLE, which masks the receiver's one-cycle registered clear latency.
REQ-015 In WAIT with rx_out[15]=0, the FSM SHALL issue a push of rx_out[7:0] in that cycle and go to ARM.
REQ-016 In WAIT with rx_out[15]=1, the FSM SHALL remain in WAIT.
REQ-017 A byte SHALL be pushed exactly once; minimum spacing between pushes is 3 cycles.
REQ-018 A push with count<DEPTH SHALL write mem[wr_ptr], increment wr_ptr modulo DEPTH, and increment count.
REQ-019 A push with count==DEPTH and pop=0 SHALL discard the byte, set overflow=1, and leave pointers and count unchanged.
REQ-020 A pop with count>0 SHALL increment rd_ptr modulo DEPTH and decrement count.
REQ-021 A pop with count==0 SHALL be ignored; no pointer change and no underflow.
REQ-022 Simultaneous push and pop with 0<count<DEPTH SHALL perform both and leave count unchanged.
REQ-023 Simultaneous push and pop with count==DEPTH SHALL apply the pop first and accept the push; overflow is not set.
REQ-024 Simultaneous push and pop with count==0 SHALL ignore the pop and accept the push; count becomes 1.
REQ-025 Overflow SHALL be sticky until clr_ovf=1; if clr_ovf and an overflowing push coincide, the flag SHALL end at 1 (set wins).
REQ-026 out SHALL be combinational from registered state: out[15]=(count==0), out[14]=overflow, out[7:0]=mem[rd_ptr] when count>0 else 8'h00.
REQ-027 A pushed byte SHALL be visible on out the cycle after the push edge; after a pop edge, out SHALL show the next entry (or empty) in the same following cycle.
REQ-028 Pointer wrap SHALL be seamless: FIFO order is preserved across wr_ptr/rd_ptr roll-over from DEPTH-1 to 0.

Reset
REQ-029 reset_n=0 SHALL immediately force FSM=ARM, wr_ptr=0, rd_ptr=0, count=0, overflow=0, regardless of clk.
REQ-030 While in reset, outputs SHALL be rx_clear=1, out=16'h8000, count=0; FIFO memory contents are don't-care.
REQ-031 After reset_n rises, rx_clear SHALL remain 1 for exactly one further clk edge (ARM) before SETTLE.
REQ-032 Reset asserted mid-capture SHALL discard any in-flight byte and all stored entries.

Verification
REQ-033 Reset release, rx_out=16'h8000 held -> rx_clear high one cycle, FSM parks in WAIT, out=16'h8000, count=0.
REQ-034 rx_out=16'h0041 for one cycle in WAIT -> next cycle out=16'h0041, count=1, rx_clear=1; pop -> out=16'h8000, count=0.
REQ-035 Push 16 bytes 0x00..0x0F with no pops, then one more byte 0x55 -> count=16, out=16'h4000, 0x55 dropped; clr_ovf -> out=16'h0000.
REQ-036 Full FIFO, push 0xAA coincident with pop -> count stays 16, overflow=0, head advances to 0x01, 0xAA is last of 16 pops.
REQ-037 Push and pop 40 bytes interleaved (0x10+i) -> every pop returns bytes in order across two pointer wraps; count never exceeds 16.
REQ-038 reset_n pulsed low asynchronously between clk edges while count=5 -> out=16'h8000, count=0 before the next edge; pop when empty -> no change.
